// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver
// Drives a bank of WIDTH SR flip-flops toward a requested Q pattern. A target
// word is accepted over valid/ready; per-bit S/R are derived from the SR
// excitation table against the bank's current Q and pulsed for one cycle.
// After a settle window the bank's Q is read back and compared to the target.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low driver reset (does not reset the bank)
//   req_valid  target word valid
//   req_ready  driver idle and able to accept a target
//   req_data   requested next Q pattern
//   q_in       Q outputs of the SR flip-flop bank
//   s_out      registered S inputs to the bank
//   r_out      registered R inputs to the bank
//   done       one-cycle pulse when readback completes
//   err        valid with done; 1 = readback mismatch (held until next done)
//   err_mask   valid with done; q_in ^ target (held until next done)
//   err_count  saturating count of mismatching transactions
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a target; S/R held at 0
// DRIVE | S/R pulse on s_out/r_out for exactly one cycle
// WAIT  | S/R released, settle counter running down to readback

module sr_excitation_driver #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [7:0]       err_count
);

  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW = $clog2(SETTLE_EFF + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_EFF);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] target, target_nx;
  logic [WIDTH-1:0] s_nx, r_nx;
  logic [WIDTH-1:0] mask_nx, readback;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             done_nx, err_nx;
  logic [7:0]       err_count_nx;

  // Ready is forced low while reset is held, even though state already reads IDLE.
  assign req_ready = rst & (state == IDLE);

  always_comb begin
    state_nx     = state;
    target_nx    = target;
    s_nx         = '0;
    r_nx         = '0;
    cnt_nx       = cnt;
    done_nx      = 1'b0;
    err_nx       = err;
    mask_nx      = err_mask;
    err_count_nx = err_count;
    readback     = q_in ^ target;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx  = DRIVE;
          target_nx = req_data;
          // Set only 0->1 bits, reset only 1->0 bits; the two masks are
          // disjoint so S=R=1 can never be produced.
          s_nx      = req_data & ~q_in;
          r_nx      = ~req_data & q_in;
        end
      end
      DRIVE: begin
        state_nx = WAIT;
        cnt_nx   = SETTLE_LD;
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          mask_nx  = readback;
          err_nx   = |readback;
          if ((|readback) && (err_count != 8'hFF)) begin
            err_count_nx = err_count + 8'd1;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      target    <= '0;
      s_out     <= '0;
      r_out     <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_mask  <= '0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      s_out     <= s_nx;
      r_out     <= r_nx;
      cnt       <= cnt_nx;
      done      <= done_nx;
      err       <= err_nx;
      err_mask  <= mask_nx;
      err_count <= err_count_nx;
    end
  end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// tb_sr_excitation_driver
// Two driver instances (SETTLE=1 and SETTLE=3), each driving its own SR
// flip-flop bank model with an optional stuck-at-0 mask. Expected S/R pulses
// and readback results are queued at acceptance and compared when produced.

module tb_sr_excitation_driver;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] mask;
    logic         e;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         rv     [2];
  logic [W-1:0] rd     [2];
  logic         rdy    [2];
  logic [W-1:0] qin    [2];
  logic [W-1:0] s_o    [2];
  logic [W-1:0] r_o    [2];
  logic         dn     [2];
  logic         er     [2];
  logic [W-1:0] emask  [2];
  logic [7:0]   ecnt   [2];
  logic         ld     [2];
  logic [W-1:0] ldv    [2];
  logic [W-1:0] stuck  [2];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SR excitation table: returns {S,R} for current q and target t.
  function automatic logic [1:0] exc(input logic q, input logic t);
    case ({q, t})
      2'b01:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : 3;

    logic [W-1:0] bank_q;
    int           cyc = 0;
    int           exp_cnt = 0;
    bit           drv_pend = 0;
    logic         last_err = 1'b0;
    logic [W-1:0] last_mask = '0;
    exp_t         drv_q[$];
    exp_t         done_q[$];

    assign qin[g] = bank_q & ~stuck[g];

    always @(posedge clk)
      bank_q <= ld[g] ? ldv[g] : ((bank_q | s_o[g]) & ~r_o[g]);

    sr_excitation_driver #(.WIDTH(W), .SETTLE(ST)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(rv[g]),
      .req_ready(rdy[g]),
      .req_data (rd[g]),
      .q_in     (qin[g]),
      .s_out    (s_o[g]),
      .r_out    (r_o[g]),
      .done     (dn[g]),
      .err      (er[g]),
      .err_mask (emask[g]),
      .err_count(ecnt[g])
    );

    always @(posedge clk) begin : p_acc
      exp_t e;
      cyc++;
      if (!rst) begin
        drv_q.delete();
        done_q.delete();
        drv_pend  = 0;
        exp_cnt   = 0;
        last_err  = 1'b0;
        last_mask = '0;
      end else if (rv[g] && rdy[g]) begin
        for (int b = 0; b < W; b++) {e.s[b], e.r[b]} = exc(qin[g][b], rd[g][b]);
        e.mask = (rd[g] & ~stuck[g]) ^ rd[g];
        e.e    = |e.mask;
        e.due  = cyc + 1 + ST;
        drv_q.push_back(e);
        done_q.push_back(e);
        drv_pend = 1;
      end
    end

    always @(negedge clk) begin : p_chk
      exp_t e;
      if (rst) begin
        chk($sformatf("sr_overlap%0d", g), s_o[g] & r_o[g], 0);
        if (drv_pend) begin
          e = drv_q.pop_front();
          drv_pend = 0;
          chk($sformatf("s_out%0d", g), s_o[g], e.s);
          chk($sformatf("r_out%0d", g), r_o[g], e.r);
        end else begin
          chk($sformatf("sr_idle%0d", g), {s_o[g], r_o[g]}, 0);
        end
        if (dn[g]) begin
          if (done_q.size() == 0) begin
            chk($sformatf("done_unexp%0d", g), 1, 0);
          end else begin
            e = done_q.pop_front();
            chk($sformatf("done_lat%0d", g), cyc, e.due);
            chk($sformatf("err%0d", g), er[g], e.e);
            chk($sformatf("err_mask%0d", g), emask[g], e.mask);
            if (e.e && exp_cnt < 255) exp_cnt++;
            chk($sformatf("err_count%0d", g), ecnt[g], exp_cnt);
            last_err  = e.e;
            last_mask = e.mask;
          end
        end else begin
          chk($sformatf("err_hold%0d", g), {er[g], emask[g]}, {last_err, last_mask});
          if (done_q.size() > 0 && cyc > done_q[0].due) begin
            chk($sformatf("done_miss%0d", g), 0, 1);
            void'(done_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_rdy(input int g);
    int n = 0;
    while (!rdy[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[g]) chk("rdy_timeout", 0, 1);
  endtask

  task automatic send(input int g, input logic [W-1:0] t);
    wait_rdy(g);
    rv[g] = 1'b1;
    rd[g] = t;
    @(negedge clk);
    rv[g] = 1'b0;
    rd[g] = ~t;
  endtask

  task automatic load(input int g, input logic [W-1:0] v);
    @(negedge clk);
    ld[g]  = 1'b1;
    ldv[g] = v;
    @(negedge clk);
    ld[g]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      rv[g] = 1'b0; rd[g] = '0; ld[g] = 1'b0; ldv[g] = '0; stuck[g] = '0;
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", rdy[0], 0);
    chk("rst_s", s_o[0], 0);
    chk("rst_r", r_o[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_cnt", ecnt[0], 0);

    ld[0] = 1'b1; ld[1] = 1'b1; ldv[0] = '0; ldv[1] = '0;
    @(negedge clk);
    @(negedge clk);
    ld[0] = 1'b0; ld[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst0", rdy[0], 1);
    chk("ready_after_rst1", rdy[1], 1);

    // set then clear, hold, on SETTLE=1 instance
    send(0, 4'b1010);
    repeat (4) @(negedge clk);
    send(0, 4'b0010);
    repeat (4) @(negedge clk);
    load(0, 4'b1100);
    send(0, 4'b1100);
    repeat (4) @(negedge clk);

    // bit 2 stuck at 0
    stuck[0] = 4'b0100;
    load(0, 4'b0000);
    send(0, 4'b0100);
    repeat (4) @(negedge clk);
    chk("mismatch_cnt", ecnt[0], 1);

    // saturation: 260 more mismatches, back to back
    for (int i = 0; i < 260; i++) send(0, 4'b0100);
    repeat (5) @(negedge clk);
    chk("cnt_sat", ecnt[0], 255);
    stuck[0] = '0;

    // reset in the middle of a DRIVE pulse
    load(0, 4'b0000);
    wait_rdy(0);
    rv[0] = 1'b1;
    rd[0] = 4'b0101;
    @(negedge clk);
    rv[0] = 1'b0;
    chk("mid_drive_s", s_o[0], 4'b0101);
    #2 rst = 1'b0;
    #1;
    chk("midrst_s", s_o[0], 0);
    chk("midrst_r", r_o[0], 0);
    chk("midrst_done", dn[0], 0);
    chk("midrst_cnt", ecnt[0], 0);
    chk("midrst_ready", rdy[0], 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready_rel", rdy[0], 1);

    // stress on SETTLE=3 instance: valid held high, 20 random targets
    @(negedge clk);
    rv[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int n;
      n = 0;
      rd[1] = 4'($urandom_range(0, 15));
      while (!rdy[1] && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (i > 0) chk("stress_gap", n, 4);
      @(negedge clk);
    end
    rv[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("stress_cnt", ecnt[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
